// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch front end: owns the PC, fetches one instruction at a time
// from instruction memory over a req/ack handshake, presents it to decode with
// its PC and PC+4, and computes the next PC from branch/jump/jr controls.
// A memory timeout or a misaligned jr target parks the unit in a sticky error
// state until reset.
//
// State table:
//   state   | meaning
//   IDLE    | leaving reset, no request outstanding
//   REQ     | imem_req high at imem_addr=pc, waiting for imem_ack
//   VALID   | instr/pc/pc_plus4 presented to decode, waiting for stall=0
//   ERR     | sticky fetch error (timeout or misaligned jr), holds until reset
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 decode not ready, hold current instruction
//   branch, jump, jr      next-PC controls, priority jr > jump > branch
//   imm, jaddr, jr_target branch offset (words), jump field, register target
//   imem_req, imem_addr   fetch request and address
//   imem_ack, imem_rdata  memory response
//   instr, instr_valid    fetched instruction and its valid flag
//   pc, pc_plus4          address of instr and its sequential successor
//   fetch_err             sticky error flag

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc_nxt;
    logic [31:0]   instr_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic [31:0]   jump_target;
    logic [31:0]   branch_target;
    logic          jr_misaligned;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], jaddr, 2'b00};
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign jr_misaligned = |jr_target[1:0];

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_VALID);
    assign fetch_err   = (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= 32'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr    <= instr_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_VALID;
                end else if (wait_cnt == CNT_LAST) begin
                    // this edge closes the TIMEOUT-th un-acked cycle
                    state_nxt = S_ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    if (jr && jr_misaligned) begin
                        // pc keeps the jr-source address for diagnosis
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_REQ;
                        if (jr)
                            pc_nxt = jr_target;
                        else if (jump)
                            pc_nxt = jump_target;
                        else if (branch)
                            pc_nxt = branch_target;
                        else
                            pc_nxt = pc_plus4;
                    end
                end
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch, jump, jr;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] jr_target;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;

    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_pc_plus4;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump),
        .jr(jr), .imm(imm), .jaddr(jaddr), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TIMEOUT)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump),
        .jr(jr), .imm(imm), .jaddr(jaddr), .jr_target(jr_target),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(w_instr), .instr_valid(w_valid),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .fetch_err(w_err)
    );

    // Reference next-PC rule: priority jr > jump > branch > sequential.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic b, input logic j,
                                             input logic r, input logic [15:0] im,
                                             input logic [25:0] ja, input logic [31:0] jt);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (r)      return jt;
        else if (j) return (seq & 32'hF000_0000) | (32'(ja) * 32'd4);
        else if (b) return seq + 32'(int'($signed(im)) * 4);
        else        return seq;
    endfunction

    task automatic junk_ctl;
        stall     = 1'($urandom);
        branch    = 1'($urandom);
        jump      = 1'($urandom);
        jr        = 1'($urandom);
        imm       = 16'($urandom);
        jaddr     = 26'($urandom);
        jr_target = $urandom;
    endtask

    task automatic clear_ctl;
        stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
        imm = 16'd0; jaddr = 26'd0; jr_target = 32'd0;
    endtask

    // Leaves the bench at a falling edge with the DUT in its first REQ cycle.
    task automatic do_reset;
        rst_n = 1'b0;
        clear_ctl();
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = 32'h0000_0000;
        @(negedge clk);
    endtask

    // One full fetch: called at a falling edge in REQ; returns at a falling
    // edge after the next-PC decision (in REQ or ERR).
    task automatic fetch_one(input int lat, input int nst, input logic b, input logic j,
                             input logic r, input logic [15:0] im, input logic [25:0] ja,
                             input logic [31:0] jt, input logic [31:0] rd, output bit erred);
        logic [31:0] exp_next;
        bit          exp_err;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_req: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, model_pc);
        end
        for (int i = 0; i < lat; i++) begin
            junk_ctl();
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== model_pc || fetch_err !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_wait: req=%b addr=%h err=%b, required req=1 addr=%h err=0",
                         imem_req, imem_addr, fetch_err, model_pc);
            end
        end
        junk_ctl();
        imem_ack   = 1'b1;
        imem_rdata = rd;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== rd || pc !== model_pc ||
            pc_plus4 !== model_pc + 32'd4 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_valid: valid=%b instr=%h pc=%h pc4=%h req=%b, required 1 %h %h %h 0",
                     instr_valid, instr, pc, pc_plus4, imem_req, rd, model_pc, model_pc + 32'd4);
        end
        for (int i = 0; i < nst; i++) begin
            junk_ctl();
            stall    = 1'b1;
            imem_ack = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== rd || imem_addr !== model_pc || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_stall: valid=%b instr=%h addr=%h req=%b, required 1 %h %h 0",
                         instr_valid, instr, imem_addr, imem_req, rd, model_pc);
            end
        end
        imem_ack  = 1'b0;
        stall     = 1'b0;
        branch    = b; jump = j; jr = r;
        imm       = im; jaddr = ja; jr_target = jt;
        exp_err   = r && (jt[1:0] != 2'b00);
        exp_next  = ref_next(model_pc, b, j, r, im, ja, jt);
        @(negedge clk);
        clear_ctl();
        n_cmp++;
        if (exp_err) begin
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== model_pc) begin
                n_bad++;
                $display("FAIL fetch_jr_err: err=%b req=%b valid=%b pc=%h, required 1 0 0 %h",
                         fetch_err, imem_req, instr_valid, pc, model_pc);
            end
        end else begin
            if (imem_req !== 1'b1 || imem_addr !== exp_next || fetch_err !== 1'b0 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_next: req=%b addr=%h err=%b valid=%b, required 1 %h 0 0",
                         imem_req, imem_addr, fetch_err, instr_valid, exp_next);
            end
            model_pc = exp_next;
        end
        erred = exp_err;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        clear_ctl();
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: pc=%h instr=%h valid=%b req=%b err=%b, required 0 0 0 0 0",
                     pc, instr, instr_valid, imem_req, fetch_err);
        end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        model_pc = 32'd0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_req: req=%b addr=%h instr=%h valid=%b, required 1 0 0 0",
                     imem_req, imem_addr, instr, instr_valid);
        end
    endtask

    task automatic test_sequential;
        bit e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (imem_addr !== 32'(4 * k)) begin
                n_bad++;
                $display("FAIL seq_addr: addr=%h, required %h", imem_addr, 32'(4 * k));
            end
            fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'(k), e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc !== 32'd0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_midreq_reset: req=%b pc=%h valid=%b, required 0 0 0", imem_req, pc, instr_valid);
        end
    endtask

    task automatic test_stall;
        bit e;
        do_reset();
        for (int k = 0; k < 4; k++)
            fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL stall_addr: addr=%h, required 00000010", imem_addr);
        end
        fetch_one(3, 4, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'hCAFE_0010, e);
    endtask

    task automatic test_branch_jump;
        bit e;
        do_reset();
        fetch_one(0, 0, 1'b0, 1'b1, 1'b0, 16'd0, 26'h40, 32'd0, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h100) begin
            n_bad++; $display("FAIL bj_jump100: addr=%h, required 00000100", imem_addr);
        end
        fetch_one(1, 0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'd0, 32'd0, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h0FC) begin
            n_bad++; $display("FAIL bj_branch_back: addr=%h, required 000000fc", imem_addr);
        end
        fetch_one(0, 1, 1'b0, 1'b0, 1'b1, 16'd0, 26'd0, 32'h1000_0040, $urandom, e);
        fetch_one(2, 0, 1'b0, 1'b1, 1'b0, 16'd0, 26'h10, 32'd0, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h1000_0040) begin
            n_bad++; $display("FAIL bj_jump_region: addr=%h, required 10000040", imem_addr);
        end
        fetch_one(0, 0, 1'b1, 1'b1, 1'b0, 16'h0004, 26'h20, 32'd0, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h1000_0080) begin
            n_bad++; $display("FAIL bj_jump_wins: addr=%h, required 10000080", imem_addr);
        end
    endtask

    task automatic test_jr;
        bit e;
        fetch_one(0, 0, 1'b0, 1'b1, 1'b1, 16'd0, 26'h55, 32'h2000, $urandom, e);
        n_cmp++;
        if (imem_addr !== 32'h2000) begin
            n_bad++; $display("FAIL jr_wins: addr=%h, required 00002000", imem_addr);
        end
        fetch_one(1, 2, 1'b1, 1'b1, 1'b1, 16'h0008, 26'h3, 32'h2002, $urandom, e);
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h2000 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL jr_err_hold: err=%b req=%b pc=%h valid=%b, required 1 0 00002000 0",
                         fetch_err, imem_req, pc, instr_valid);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        bit e;
        do_reset();
        for (int k = 1; k <= TIMEOUT; k++) begin
            junk_ctl();
            n_cmp++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait%0d: req=%b err=%b, required 1 0", k, imem_req, fetch_err);
            end
            @(negedge clk);
        end
        clear_ctl();
        n_cmp++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'd0) begin
            n_bad++;
            $display("FAIL timeout_err: err=%b req=%b pc=%h, required 1 0 0", fetch_err, imem_req, pc);
        end
        do_reset();
        fetch_one(TIMEOUT - 1, 0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'h1234_5678, e);
    endtask

    task automatic test_wrap;
        do_reset();
        n_cmp++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_first: req=%b addr=%h pc4=%h, required 1 fffffffc 0", w_req, w_addr, w_pc_plus4);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hABCD_0001;
        @(negedge clk);
        imem_ack = 1'b0;
        n_cmp++;
        if (w_valid !== 1'b1 || w_instr !== 32'hABCD_0001 || w_pc !== 32'hFFFF_FFFC || w_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_valid: valid=%b instr=%h pc=%h err=%b, required 1 abcd0001 fffffffc 0",
                     w_valid, w_instr, w_pc, w_err);
        end
        @(negedge clk);
        n_cmp++;
        if (w_req !== 1'b1 || w_addr !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL wrap_second: req=%b addr=%h, required 1 00000000", w_req, w_addr);
        end
    endtask

    task automatic test_random;
        bit          e;
        logic        r;
        logic [31:0] jt;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            r  = ($urandom_range(0, 3) == 0);
            jt = $urandom;
            if ($urandom_range(0, 4) != 0)
                jt[1:0] = 2'b00;
            fetch_one(int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), r, 16'($urandom), 26'($urandom), jt, $urandom, e);
            if (e)
                do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_jump();
        test_jr();
        test_timeout();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch front end of the single-issue MIPS datapath. Owns the program counter and issues fetch requests to instruction memory over a req/ack handshake. Presents each fetched instruction with its PC and PC+4 to decode. Computes the next PC from the taken-branch, jump and jump-register controls returned by decode/execute, and flags a sticky error on memory timeout or a misaligned jr target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
TIMEOUT, 16, consecutive un-acked REQ cycles before fetch error (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
stall  in  1  decode not ready; hold current instruction
branch  in  1  taken branch (branch AND Z already combined)
jump  in  1  j/jal
jr  in  1  jump register
imm  in  16  branch offset in words, signed
jaddr  in  26  jump target field
jr_target  in  32  register jump target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
instr  out  32  fetched instruction
instr_valid  out  1  instr/pc/pc_plus4 valid
pc  out  32  address of instr
pc_plus4  out  32  pc + 4, mod 2^32, combinational from pc
fetch_err  out  1  sticky error

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active low. While rst_n=0: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0, state=IDLE. Outputs take these values immediately on assertion, including mid-request.
- State machine: IDLE, REQ, VALID, ERR.
- IDLE: outputs idle. Moves to REQ on the first edge after rst_n deasserts. Any imem_ack in IDLE is ignored.
- REQ:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, counter<=0, go to VALID.
  - Ack may arrive in the first REQ cycle, so minimum latency is request cycle N, instr_valid at N+1.
  - On imem_ack=0: counter increments. The edge that ends the TIMEOUT-th consecutive un-acked cycle goes to ERR.
  - stall is ignored in REQ.
- VALID:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold all registers.
  - If stall=0: pc<=next_pc, go to REQ. instr_valid drops the next cycle (one bubble per fetch).
  - Control inputs are sampled only in VALID with stall=0.
- next_pc priority: jr > jump > branch > sequential.
  - jr: jr_target. If jr_target[1:0]!=0, go to ERR instead; pc is not updated.
  - jump: {pc_plus4[31:28], jaddr, 2'b00}.
  - branch: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), mod 2^32.
  - else: pc_plus4 (0xFFFF_FFFC wraps to 0x0000_0000).
- ERR: fetch_err=1, imem_req=0, instr_valid=0. Holds until reset; pc holds the faulting fetch or jr-source pc.
- imem_ack outside REQ has no effect.
- Simultaneous controls: lower-priority controls are ignored and no error is raised. Exception: jr with a misaligned target errors even if jump or branch is also asserted.

Test Plan:
- Reset/sequential: rst_n low then high, RESET_PC=0, ack 0-cycle latency, rdata=i -> imem_addr sequence 0x0,0x4,0x8, instr_valid every 2nd cycle. Assert rst_n mid-REQ -> imem_req=0 immediately and pc=0.
- Ack latency and stall: ack after 3 cycles, then stall=1 for 4 cycles in VALID -> imem_addr held 0x10 for 4 cycles, instr held, no new req until stall=0.
- Branch/jump: pc=0x100, branch=1, imm=0xFFFE -> next imem_addr 0xFC. pc=0x1000_0040, jump=1, jaddr=0x10 -> 0x1000_0040. Both asserted -> jump wins.
- jr: jr=1, jump=1, jr_target=0x2000 -> next addr 0x2000. jr_target=0x2002 -> fetch_err=1, imem_req=0, pc unchanged.
- Timeout: TIMEOUT=16, ack never asserted -> fetch_err rises after exactly 16 REQ cycles. Ack in the 16th cycle -> no error, instr captured.
- Wrap: RESET_PC=0xFFFF_FFFC, sequential -> second fetch address 0x0000_0000.
